pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/point/over FSM, paddle and ball physics, one 3-cycle update per frame_tick in PLAY.
// Optional macro PONG_SPEEDUP_EN: ball speed +1 per 4 paddle hits (max 4), back to 2 on every serve.
module pong_game_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int PADDLE_H  = 64,
  parameter int BALL_SZ   = 8,
  parameter int PAD_STEP  = 4,
  parameter int WIN_SCORE = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       busy,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;

  localparam logic [9:0] CTR_X   = 10'((SCREEN_W - BALL_SZ) / 2);
  localparam logic [9:0] CTR_Y   = 10'((SCREEN_H - BALL_SZ) / 2);
  localparam logic [9:0] PAD_MAX = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] PAD_RST = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] STEP    = 10'(PAD_STEP);
  localparam logic [9:0] L_FACE  = 10'd24;
  localparam logic [9:0] R_FACE  = 10'd616 - 10'(BALL_SZ);
  localparam logic [9:0] Y_BOT   = 10'(SCREEN_H - BALL_SZ);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [5:0] SERVE_LAST = 6'd29;
  localparam logic [5:0] POINT_LAST = 6'd59;

  state_t             state;
  logic [1:0]         phase;
  logic               dx_left, dy_up, concede_left;
  logic [5:0]         frame_cnt;
  logic signed [10:0] cand_x, cand_y;
  logic [2:0]         speed;

  logic signed [10:0] bx_s, by_s, spd_s;
  logic [10:0]        by_u;
  logic               miss_l, miss_r, miss, ovl_l, ovl_r, hit_l, hit_r, win;

  assign busy    = (phase != 2'd0);
  assign state_o = state;
  assign win     = (score_l == WIN) || (score_r == WIN);

  assign bx_s  = signed'({1'b0, ball_x});
  assign by_s  = signed'({1'b0, ball_y});
  assign spd_s = signed'({8'd0, speed});
  assign by_u  = {1'b0, ball_y};

  // Collision terms evaluated against the candidate; the ball row used for paddle overlap is the pre-move one.
  assign miss_l = (cand_x <= 11'sd0);
  assign miss_r = (cand_x >= signed'(11'(SCREEN_W - BALL_SZ)));
  assign miss   = miss_l || miss_r;
  assign ovl_l  = (by_u + 11'(BALL_SZ) > {1'b0, pad_l_y}) && (by_u < {1'b0, pad_l_y} + 11'(PADDLE_H));
  assign ovl_r  = (by_u + 11'(BALL_SZ) > {1'b0, pad_r_y}) && (by_u < {1'b0, pad_r_y} + 11'(PADDLE_H));
  assign hit_l  = !miss && dx_left && (cand_x <= signed'({1'b0, L_FACE})) && (ball_x >= L_FACE) && ovl_l;
  assign hit_r  = !miss && !dx_left && (cand_x >= signed'({1'b0, R_FACE})) && (ball_x <= R_FACE) && ovl_r;

  function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
    if (up && !dn) return (y < STEP) ? 10'd0 : y - STEP;
    if (dn && !up) return (y > PAD_MAX - STEP) ? PAD_MAX : y + STEP;
    return y;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? s : s + 4'd1;
  endfunction

`ifdef PONG_SPEEDUP_EN
  logic [1:0] hit_cnt;
  logic       hit_now, enter_serve;
  assign hit_now     = (state == PLAY) && (phase == 2'd3) && (hit_l || hit_r);
  assign enter_serve = ((state == IDLE || state == OVER) && serve) ||
                       ((state == POINT) && frame_tick && (frame_cnt == POINT_LAST) && !win);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed   <= 3'd2;
      hit_cnt <= 2'd0;
    end else if (enter_serve) begin
      speed   <= 3'd2;
      hit_cnt <= 2'd0;
    end else if (hit_now) begin
      hit_cnt <= hit_cnt + 2'd1;
      if (hit_cnt == 2'd3 && speed < 3'd4) speed <= speed + 3'd1;
    end
  end
`else
  assign speed = 3'd2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= 2'd0;
      ball_x       <= CTR_X;
      ball_y       <= CTR_Y;
      dx_left      <= 1'b0;
      dy_up        <= 1'b0;
      concede_left <= 1'b0;
      pad_l_y      <= PAD_RST;
      pad_r_y      <= PAD_RST;
      score_l      <= 4'd0;
      score_r      <= 4'd0;
      game_over    <= 1'b0;
      frame_cnt    <= 6'd0;
      cand_x       <= 11'sd0;
      cand_y       <= 11'sd0;
    end else begin
      case (state)
        IDLE: if (serve) begin
          state     <= SERVE;
          frame_cnt <= 6'd0;
        end
        SERVE: if (frame_tick) begin
          pad_l_y <= pad_next(pad_l_y, btn_l_up, btn_l_dn);
          pad_r_y <= pad_next(pad_r_y, btn_r_up, btn_r_dn);
          if (frame_cnt == SERVE_LAST) begin
            state     <= PLAY;
            frame_cnt <= 6'd0;
          end else begin
            frame_cnt <= frame_cnt + 6'd1;
          end
        end
        PLAY: begin
          case (phase)
            2'd0: if (frame_tick) phase <= 2'd1;
            2'd1: begin
              pad_l_y <= pad_next(pad_l_y, btn_l_up, btn_l_dn);
              pad_r_y <= pad_next(pad_r_y, btn_r_up, btn_r_dn);
              phase   <= 2'd2;
            end
            2'd2: begin
              cand_x <= dx_left ? bx_s - spd_s : bx_s + spd_s;
              cand_y <= dy_up   ? by_s - spd_s : by_s + spd_s;
              phase  <= 2'd3;
            end
            default: begin
              phase <= 2'd0;
              if (cand_y <= 11'sd0) begin
                ball_y <= 10'd0;
                dy_up  <= 1'b0;
              end else if (cand_y >= signed'({1'b0, Y_BOT})) begin
                ball_y <= Y_BOT;
                dy_up  <= 1'b1;
              end else begin
                ball_y <= cand_y[9:0];
              end
              // A miss recentres the ball, overriding the wall result above.
              if (miss) begin
                ball_x       <= CTR_X;
                ball_y       <= CTR_Y;
                state        <= POINT;
                frame_cnt    <= 6'd0;
                concede_left <= miss_l;
                if (miss_l) score_r <= sat_inc(score_r);
                else        score_l <= sat_inc(score_l);
              end else if (hit_l) begin
                ball_x  <= L_FACE;
                dx_left <= 1'b0;
              end else if (hit_r) begin
                ball_x  <= R_FACE;
                dx_left <= 1'b1;
              end else begin
                ball_x <= cand_x[9:0];
              end
            end
          endcase
        end
        POINT: if (frame_tick) begin
          if (frame_cnt == POINT_LAST) begin
            frame_cnt <= 6'd0;
            if (win) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state   <= SERVE;
              dx_left <= concede_left;
            end
          end else begin
            frame_cnt <= frame_cnt + 6'd1;
          end
        end
        OVER: if (serve) begin
          state     <= SERVE;
          score_l   <= 4'd0;
          score_r   <= 4'd0;
          game_over <= 1'b0;
          frame_cnt <= 6'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: frame-level reference model, scenario tasks plus randomized play.
module tb_pong_game_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, serve = 1'b0;
  logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic       game_over, busy;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: one call per accepted frame tick, states 0..4 = IDLE..OVER.
  int m_st, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_go, m_cnt, m_hits, m_concl;
  bit ev_hit_l, ev_miss;

  logic [52:0] obs;
  assign obs = {state_o, ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_over, busy};

  function automatic logic [52:0] exp_v();
    return {3'(m_st), 10'(m_bx), 10'(m_by), 10'(m_pl), 10'(m_pr), 4'(m_sl), 4'(m_sr), 1'(m_go), 1'b0};
  endfunction

  function automatic int model_speed();
`ifdef PONG_SPEEDUP_EN
    return 2 + ((m_hits / 4 > 2) ? 2 : m_hits / 4);
`else
    return 2;
`endif
  endfunction

  function automatic int padmv(int p, bit up, bit dn);
    if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
    return p;
  endfunction

  function automatic bit ovl(int by, int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_reset();
    m_st = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_pl = 208; m_pr = 208;
    m_sl = 0; m_sr = 0; m_go = 0; m_cnt = 0; m_hits = 0; m_concl = 0;
  endtask

  task automatic model_serve();
    if (m_st == 0 || m_st == 4) begin
      if (m_st == 4) begin m_sl = 0; m_sr = 0; m_go = 0; end
      m_st = 1; m_cnt = 0; m_hits = 0;
    end
  endtask

  task automatic model_tick(bit ul, bit dl, bit ur, bit dr);
    int cx, cy, ny, spd;
    ev_hit_l = 0; ev_miss = 0;
    if (m_st == 1) begin
      m_pl = padmv(m_pl, ul, dl); m_pr = padmv(m_pr, ur, dr);
      m_cnt++;
      if (m_cnt == 30) begin m_st = 2; m_cnt = 0; end
    end else if (m_st == 2) begin
      m_pl = padmv(m_pl, ul, dl); m_pr = padmv(m_pr, ur, dr);
      spd = model_speed();
      cx = m_bx + m_dx * spd;
      cy = m_by + m_dy * spd;
      if (cy <= 0) begin ny = 0; m_dy = 1; end
      else if (cy >= 472) begin ny = 472; m_dy = -1; end
      else ny = cy;
      if (cx <= 0 || cx >= 632) begin
        ev_miss = 1;
        m_concl = (cx <= 0);
        if (cx <= 0) m_sr = (m_sr < 9) ? m_sr + 1 : m_sr;
        else         m_sl = (m_sl < 9) ? m_sl + 1 : m_sl;
        m_st = 3; m_cnt = 0; m_bx = 316; ny = 236;
      end else if (m_dx < 0 && cx <= 24 && m_bx >= 24 && ovl(m_by, m_pl)) begin
        m_bx = 24; m_dx = 1; m_hits++; ev_hit_l = 1;
      end else if (m_dx > 0 && cx >= 608 && m_bx <= 608 && ovl(m_by, m_pr)) begin
        m_bx = 608; m_dx = -1; m_hits++;
      end else begin
        m_bx = cx;
      end
      m_by = ny;
    end else if (m_st == 3) begin
      m_cnt++;
      if (m_cnt == 60) begin
        m_cnt = 0;
        if (m_sl == 9 || m_sr == 9) begin m_st = 4; m_go = 1; end
        else begin m_st = 1; m_dx = m_concl ? -1 : 1; m_hits = 0; end
      end
    end
  endtask

  // Paddle policies from the model's view of the ball.
  task automatic track(input int pad, output bit up, output bit dn);
    up = (pad > m_by - 28 + 3);
    dn = (pad < m_by - 28 - 3);
  endtask

  task automatic avoid(output bit up, output bit dn);
    up = (m_by >= 236);
    dn = !up;
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; serve = 1'b0;
    {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn} = 4'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic do_serve();
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    model_serve();
  endtask

  task automatic do_frame(bit ul, bit dl, bit ur, bit dr);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn} = {ul, dl, ur, dr};
    frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    model_tick(ul, dl, ur, dr);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin errors++; $display("FAIL reset_ball got %0d,%0d exp 316,236", ball_x, ball_y); end
    checks++; if (pad_l_y !== 10'd208 || pad_r_y !== 10'd208) begin errors++; $display("FAIL reset_pads got %0d,%0d exp 208,208", pad_l_y, pad_r_y); end
    checks++; if ({score_l, score_r, game_over, busy} !== 10'd0) begin errors++; $display("FAIL reset_misc got %h exp 0", {score_l, score_r, game_over, busy}); end
  endtask

  task automatic test_serve();
    int nb;
    bit moved;
    do_reset();
    do_serve();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL serve_state got %0d exp 1", state_o); end
    for (int i = 0; i < 30; i++) do_frame(0, 0, 0, 0);
    checks++; if (state_o !== 3'd2 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
      errors++; $display("FAIL serve_to_play got st=%0d ball=%0d,%0d exp st=2 ball=316,236", state_o, ball_x, ball_y); end
    nb = 0; moved = 0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) begin nb++; if (ball_x !== 10'd316) moved = 1; end
      @(negedge clk);
    end
    model_tick(0, 0, 0, 0);
    checks++; if (nb != 3) begin errors++; $display("FAIL busy_width got %0d exp 3", nb); end
    checks++; if (moved) begin errors++; $display("FAIL early_commit got 1 exp 0"); end
    checks++; if (ball_x !== 10'd318 || ball_y !== 10'd238) begin errors++; $display("FAIL first_step got %0d,%0d exp 318,238", ball_x, ball_y); end
  endtask

  task automatic test_paddles();
    do_reset();
    do_serve();
    for (int i = 1; i <= 60; i++) begin
      do_frame(1, 0, 0, 1);
      checks++; if (obs !== exp_v()) begin errors++; $display("FAIL pad_frame%0d got %h exp %h", i, obs, exp_v()); end
      if (i == 51) begin checks++; if (pad_l_y !== 10'd4) begin errors++; $display("FAIL pad_l_51 got %0d exp 4", pad_l_y); end end
      if (i >= 52) begin checks++; if (pad_l_y !== 10'd0 || pad_r_y !== 10'd416) begin
        errors++; $display("FAIL pad_sat_%0d got %0d,%0d exp 0,416", i, pad_l_y, pad_r_y); end end
    end
  endtask

  task automatic test_hit_and_miss();
    int ph;
    bit ul, dl, ur, dr;
    do_reset();
    do_serve();
    for (int i = 0; i < 30; i++) do_frame(0, 0, 0, 0);
    ph = 0;
    for (int f = 0; f < 2000 && ph < 3; f++) begin
      track(m_pr, ur, dr);
      if (ph == 0) track(m_pl, ul, dl); else avoid(ul, dl);
      do_frame(ul, dl, ur, dr);
      checks++; if (obs !== exp_v()) begin errors++; $display("FAIL rally_frame%0d got %h exp %h", f, obs, exp_v()); end
      if (ph == 0 && ev_hit_l) begin
        checks++; if (ball_x !== 10'd24) begin errors++; $display("FAIL left_hit_x got %0d exp 24", ball_x); end
        ph = 1;
      end else if (ph == 1) begin
        checks++; if (ball_x !== 10'd26) begin errors++; $display("FAIL dx_flip got %0d exp 26", ball_x); end
        ph = 2;
      end else if (ph == 2 && ev_miss) begin
        checks++; if (score_r !== 4'd1 || state_o !== 3'd3) begin
          errors++; $display("FAIL left_miss got sr=%0d st=%0d exp sr=1 st=3", score_r, state_o); end
        ph = 3;
      end
    end
    if (ph != 3) begin errors++; $display("FAIL rally_timeout got phase %0d exp 3", ph); end
    for (int i = 1; i <= 60; i++) begin
      do_frame(0, 0, 0, 0);
      if (i == 59) begin checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL point_hold got %0d exp 3", state_o); end end
    end
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL point_exit got %0d exp 1", state_o); end
  endtask

  task automatic test_win();
    bit ul, dl, ur, dr, won;
    int pre;
    do_reset();
    do_serve();
    won = 0;
    for (int f = 0; f < 4000 && !won; f++) begin
      track(m_pl, ul, dl);
      avoid(ur, dr);
      pre = m_sl;
      do_frame(ul, dl, ur, dr);
      checks++; if (obs !== exp_v()) begin errors++; $display("FAIL game_frame%0d got %h exp %h", f, obs, exp_v()); end
      if (pre == 8 && m_sl == 9) begin
        won = 1;
        checks++; if (score_l !== 4'd9 || state_o !== 3'd3) begin
          errors++; $display("FAIL ninth_point got sl=%0d st=%0d exp sl=9 st=3", score_l, state_o); end
      end
    end
    if (!won) begin errors++; $display("FAIL game_timeout got sl=%0d exp 9", score_l); end
    for (int i = 0; i < 60; i++) do_frame(1, 0, 0, 1);
    checks++; if (state_o !== 3'd4 || game_over !== 1'b1) begin
      errors++; $display("FAIL game_over got st=%0d go=%0d exp st=4 go=1", state_o, game_over); end
    do_frame(1, 0, 1, 0);
    checks++; if (obs !== exp_v()) begin errors++; $display("FAIL over_frozen got %h exp %h", obs, exp_v()); end
    do_serve();
    checks++; if (score_l !== 4'd0 || score_r !== 4'd0 || state_o !== 3'd1 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart got sl=%0d sr=%0d st=%0d go=%0d exp 0 0 1 0", score_l, score_r, state_o, game_over); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_serve();
    for (int i = 0; i < 30; i++) do_frame(0, 0, 0, 0);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    model_tick(0, 0, 0, 0);
    checks++; if (ball_x !== 10'd318 || obs !== exp_v()) begin
      errors++; $display("FAIL double_tick got x=%0d vec=%h exp x=318 vec=%h", ball_x, obs, exp_v()); end
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1;
    model_reset();
    checks++; if (obs !== exp_v()) begin errors++; $display("FAIL rst_midupdate got %h exp %h", obs, exp_v()); end
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (obs !== exp_v()) begin errors++; $display("FAIL rst_no_commit got %h exp %h", obs, exp_v()); end
  endtask

  task automatic test_random();
    bit [3:0] b;
    do_reset();
    for (int f = 0; f < 800; f++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_serve();
        checks++; if (obs !== exp_v()) begin errors++; $display("FAIL rand_serve%0d got %h exp %h", f, obs, exp_v()); end
      end
      b = 4'($urandom);
      do_frame(b[3], b[2], b[1], b[0]);
      checks++; if (obs !== exp_v()) begin errors++; $display("FAIL rand_frame%0d got %h exp %h", f, obs, exp_v()); end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddles();
    test_hit_and_miss();
    test_win();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
